mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 28 ++
 rtl/mem_access_ctrl.sv | 72 +++++++
 tb/tb_mem_access_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response handshake plus data-RAM port for mem_access_ctrl
interface mem_access_ctrl_if #(parameter int ADDR_W = 10);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_we;
    logic              ram_ld;
    logic [3:0]        ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, ram_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_we, ram_ld, ram_sel, ram_addr, ram_din
    );
    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, ram_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_we, ram_ld, ram_sel, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store controller in front of a word-wide data RAM.
// Define MISALIGN_CHECK_EN to report misaligned H/W accesses as errors instead of aligning them down.
module mem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input logic               clk,
    input logic               rst,
    mem_access_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nxt;
    logic              we_q, err_q;
    logic [2:0]        op_q;
    logic [ADDR_W+1:0] addr_q, addr_al;
    logic [31:0]       wdata_q, rdata_q, lane, ext, din;
    logic [3:0]        sel;
    logic              accept, illegal, misalign, err_in;
    always_comb begin
        accept   = state == IDLE && bus.req_valid;
        illegal  = bus.req_we ? (bus.req_op[2] || bus.req_op[1:0] == 2'b11)
                              : (bus.req_op[1:0] == 2'b11 || bus.req_op == 3'b110);
`ifdef MISALIGN_CHECK_EN
        misalign = (bus.req_op[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_op[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        err_in   = illegal || misalign;
        // Without the misalignment check, H/W offsets are silently aligned down here
        addr_al  = {bus.req_addr[ADDR_W+1:2],
                    bus.req_op[1] ? 2'b00 : bus.req_op[0] ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0]};
        state_nxt = state == IDLE  ? (accept ? (err_in ? RESP : ISSUE) : IDLE) :
                    state == ISSUE ? RESP : IDLE;
        sel  = op_q[1] ? 4'b1111 : op_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
        din  = op_q[1] ? wdata_q : op_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
        lane = bus.ram_dout >> {addr_q[1:0], 3'b000};
        ext  = op_q[1] ? bus.ram_dout :
               op_q[0] ? {{16{~op_q[2] & lane[15]}}, lane[15:0]} : {{24{~op_q[2] & lane[7]}}, lane[7:0]};
        bus.req_ready  = state == IDLE;
        bus.resp_valid = state == RESP;
        bus.resp_err   = state == RESP && err_q;
        bus.resp_rdata = rdata_q;
        bus.ram_we     = state == ISSUE && we_q;
        bus.ram_ld     = state == ISSUE && !we_q;
        bus.ram_sel    = state == ISSUE ? sel : 4'b0000;
        bus.ram_addr   = addr_q[ADDR_W+1:2];
        bus.ram_din    = din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            err_q   <= err_in;
            op_q    <= bus.req_op;
            addr_q  <= addr_al;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
        end else if (state == ISSUE && !we_q) begin
            rdata_q <= ext;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed-vector bench for mem_access_ctrl with a byte-lane RAM model
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_access_ctrl_if #(.ADDR_W(10)) bus();
    mem_access_ctrl #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    logic [31:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    assign bus.ram_dout = mem[bus.ram_addr];
    always @(posedge clk)
        if (bus.ram_we)
            for (int i = 0; i < 4; i++)
                if (bus.ram_sel[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_din[8*i +: 8];
    int n_cmp = 0, n_bad = 0;
    int obs_lat, obs_we_cnt, obs_ld_cnt;
    logic [31:0] obs_rdata, obs_din;
    logic [3:0] obs_sel;
    logic [9:0] obs_addr;
    logic obs_err;

    task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_op = 3'b011; bus.req_addr = ~addr; bus.req_wdata = ~wdata;
        obs_lat = 0; obs_we_cnt = 0; obs_ld_cnt = 0; obs_rdata = '0; obs_err = 1'b0;
        obs_sel = '0; obs_addr = '0; obs_din = '0;
        for (int k = 1; k <= 5; k++) begin
            if (bus.resp_valid) begin
                obs_lat = k; obs_rdata = bus.resp_rdata; obs_err = bus.resp_err;
                break;
            end
            if (bus.ram_we) begin obs_we_cnt++; obs_sel = bus.ram_sel; obs_addr = bus.ram_addr; obs_din = bus.ram_din; end
            if (bus.ram_ld) begin obs_ld_cnt++; obs_sel = bus.ram_sel; obs_addr = bus.ram_addr; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
        n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
        n_cmp++; if ({bus.ram_we, bus.ram_ld, bus.ram_sel} !== 6'b0) begin n_bad++; $display("FAIL reset_ram_ctl: got %b want 000000", {bus.ram_we, bus.ram_ld, bus.ram_sel}); end
        n_cmp++; if (bus.ram_addr !== 10'h0) begin n_bad++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr); end
        n_cmp++; if (bus.ram_din !== 32'h0) begin n_bad++; $display("FAIL reset_ram_din: got %h want 0", bus.ram_din); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_word;
        run_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        n_cmp++; if (obs_we_cnt !== 1) begin n_bad++; $display("FAIL sw_we_pulses: got %0d want 1", obs_we_cnt); end
        n_cmp++; if (obs_sel !== 4'b1111) begin n_bad++; $display("FAIL sw_sel: got %b want 1111", obs_sel); end
        n_cmp++; if (obs_addr !== 10'd4) begin n_bad++; $display("FAIL sw_addr: got %0d want 4", obs_addr); end
        n_cmp++; if (obs_din !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_din: got %h want deadbeef", obs_din); end
        n_cmp++; if (obs_lat !== 2 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin n_bad++; $display("FAIL sw_resp: lat %0d err %b rdata %h want 2 0 0", obs_lat, obs_err, obs_rdata); end
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        n_cmp++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", obs_rdata); end
        n_cmp++; if (obs_lat !== 2 || obs_ld_cnt !== 1 || obs_we_cnt !== 0) begin n_bad++; $display("FAIL lw_timing: lat %0d ld %0d we %0d want 2 1 0", obs_lat, obs_ld_cnt, obs_we_cnt); end
    endtask

    task automatic test_byte;
        run_req(1'b1, 3'b000, 32'h0000_0013, 32'h1234_5680);
        n_cmp++; if (obs_sel !== 4'b1000) begin n_bad++; $display("FAIL sb_sel: got %b want 1000", obs_sel); end
        n_cmp++; if (obs_din !== 32'h8080_8080) begin n_bad++; $display("FAIL sb_din: got %h want 80808080", obs_din); end
        run_req(1'b0, 3'b000, 32'h0000_0013, 32'h0);
        n_cmp++; if (obs_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
        run_req(1'b0, 3'b100, 32'h0000_0013, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_rdata: got %h want 00000080", obs_rdata); end
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h80AD_BEEF) begin n_bad++; $display("FAIL lw_after_sb: got %h want 80adbeef", obs_rdata); end
    endtask

    task automatic test_half;
        run_req(1'b1, 3'b001, 32'h0000_0022, 32'h0000_8001);
        n_cmp++; if (obs_sel !== 4'b1100 || obs_addr !== 10'd8) begin n_bad++; $display("FAIL sh_sel_addr: got %b/%0d want 1100/8", obs_sel, obs_addr); end
        n_cmp++; if (obs_din !== 32'h8001_8001) begin n_bad++; $display("FAIL sh_din: got %h want 80018001", obs_din); end
        run_req(1'b0, 3'b001, 32'h0000_0022, 32'h0);
        n_cmp++; if (obs_rdata !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_rdata: got %h want ffff8001", obs_rdata); end
        run_req(1'b0, 3'b101, 32'h0000_0022, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_rdata: got %h want 00008001", obs_rdata); end
        run_req(1'b0, 3'b101, 32'hFFFF_F020, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h0000_0000 || obs_addr !== 10'd8) begin n_bad++; $display("FAIL lhu_hi_addr: got %h @%0d want 0 @8", obs_rdata, obs_addr); end
    endtask

    task automatic test_misalign;
        run_req(1'b0, 3'b010, 32'h0000_0011, 32'h0);
`ifdef MISALIGN_CHECK_EN
        n_cmp++; if (obs_err !== 1'b1 || obs_lat !== 1) begin n_bad++; $display("FAIL mis_w_err: err %b lat %0d want 1 1", obs_err, obs_lat); end
        n_cmp++; if (obs_ld_cnt !== 0 || obs_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_w_noaccess: ld %0d rdata %h want 0 0", obs_ld_cnt, obs_rdata); end
`else
        n_cmp++; if (obs_err !== 1'b0 || obs_lat !== 2) begin n_bad++; $display("FAIL mis_w_err: err %b lat %0d want 0 2", obs_err, obs_lat); end
        n_cmp++; if (obs_rdata !== 32'h80AD_BEEF) begin n_bad++; $display("FAIL mis_w_rdata: got %h want 80adbeef", obs_rdata); end
`endif
        run_req(1'b0, 3'b001, 32'h0000_0023, 32'h0);
`ifdef MISALIGN_CHECK_EN
        n_cmp++; if (obs_err !== 1'b1 || obs_ld_cnt !== 0) begin n_bad++; $display("FAIL mis_h: err %b ld %0d want 1 0", obs_err, obs_ld_cnt); end
`else
        n_cmp++; if (obs_rdata !== 32'hFFFF_8001 || obs_sel !== 4'b1100) begin n_bad++; $display("FAIL mis_h: rdata %h sel %b want ffff8001 1100", obs_rdata, obs_sel); end
`endif
    endtask

    task automatic test_illegal;
        run_req(1'b0, 3'b111, 32'h0000_0010, 32'h0);
        n_cmp++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin n_bad++; $display("FAIL ill_ld: err %b rdata %h want 1 0", obs_err, obs_rdata); end
        n_cmp++; if (obs_lat !== 1 || obs_ld_cnt !== 0) begin n_bad++; $display("FAIL ill_ld_timing: lat %0d ld %0d want 1 0", obs_lat, obs_ld_cnt); end
        run_req(1'b1, 3'b100, 32'h0000_0010, 32'hFFFF_FFFF);
        n_cmp++; if (obs_err !== 1'b1 || obs_we_cnt !== 0) begin n_bad++; $display("FAIL ill_st: err %b we %0d want 1 0", obs_err, obs_we_cnt); end
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h80AD_BEEF) begin n_bad++; $display("FAIL ill_st_nowrite: got %h want 80adbeef", obs_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] we_pat, vld_pat, rdy_pat;
        we_pat = '0; vld_pat = '0; rdy_pat = '0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_op = 3'b010; bus.req_addr = 32'h40; bus.req_wdata = 32'h1111_1111;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            #1;
            we_pat[k] = bus.ram_we; vld_pat[k] = bus.resp_valid; rdy_pat[k] = bus.req_ready;
            if (k < 5) @(posedge clk);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (we_pat !== 6'b001001) begin n_bad++; $display("FAIL b2b_we: got %b want 001001", we_pat); end
        n_cmp++; if (vld_pat !== 6'b010010) begin n_bad++; $display("FAIL b2b_resp_valid: got %b want 010010", vld_pat); end
        n_cmp++; if (rdy_pat !== 6'b100100) begin n_bad++; $display("FAIL b2b_ready: got %b want 100100", rdy_pat); end
        run_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL b2b_data: got %h want 11111111", obs_rdata); end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_op = 3'b010; bus.req_addr = 32'h50; bus.req_wdata = 32'h5555_5555;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL rmid_issue_we: got %b want 1", bus.ram_we); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.ram_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_async: we %b rdy %b vld %b want 0 1 0", bus.ram_we, bus.req_ready, bus.resp_valid); end
        @(negedge clk) rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (bus.resp_valid) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rmid_no_resp: got %0d resp want 0", seen); end
        run_req(1'b0, 3'b010, 32'h0000_0050, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h0 || obs_lat !== 2) begin n_bad++; $display("FAIL rmid_no_write: rdata %h lat %0d want 0 2", obs_rdata, obs_lat); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = 3'b000; bus.req_addr = '0; bus.req_wdata = '0;
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_misalign;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
